// File: rtl/keypad_pkg.sv
// Shared key codes, operation and entry-state encodings for the keypad calculator path.
package keypad_pkg;

    localparam int unsigned OPERAND_W = 10;

    localparam logic [3:0] KEY_ADD  = 4'd10;
    localparam logic [3:0] KEY_SUB  = 4'd11;
    localparam logic [3:0] KEY_MUL  = 4'd12;
    localparam logic [3:0] KEY_CLR  = 4'd13;
    localparam logic [3:0] KEY_EQ   = 4'd14;
    localparam logic [3:0] KEY_NONE = 4'd15;

    // 2'b11 is reserved and never produced
    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpMul = 2'b10
    } op_t;

    typedef enum logic [1:0] {
        StA   = 2'b00,
        StOp  = 2'b01,
        StB   = 2'b10,
        StReq = 2'b11
    } entry_state_t;

    // x*10 + d using shifts; the result wraps at OPERAND_W bits, which never
    // happens with the three-digit limit
    function automatic logic [OPERAND_W-1:0] acc_digit(input logic [OPERAND_W-1:0] x,
                                                       input logic [3:0] d);
        return (x << 3) + (x << 1) + {{(OPERAND_W-4){1'b0}}, d};
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_operator(input logic [3:0] code);
        return (code == KEY_ADD) || (code == KEY_SUB) || (code == KEY_MUL);
    endfunction

    // Only meaningful for operator codes
    function automatic op_t key_to_op(input logic [3:0] code);
        op_t o;
        unique case (code)
            KEY_SUB: o = OpSub;
            KEY_MUL: o = OpMul;
            default: o = OpAdd;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/key_event_detect.sv
// Turns a held key_valid level into a single-cycle event strobe with its code.
module key_event_detect (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_event,
    output logic [3:0] event_code
);

    logic key_valid_q;

    // Remember the previous key_valid level for rising-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= key_valid;
        end
    end

    // Code is consumed in the same cycle as the strobe, so it passes straight through
    always_comb begin
        key_event  = key_valid & ~key_valid_q;
        event_code = key_code;
    end

endmodule

// File: rtl/operand_entry.sv
// Assembles keypad events into a two-operand arithmetic request with a valid/ready
// handshake toward the arithmetic stage.
// Optional feature: define OPERAND_TIMEOUT_EN to auto-clear an idle partial entry
// after TIMEOUT_CYCLES cycles.
module operand_entry
    import keypad_pkg::*;
#(
    parameter int unsigned MAX_DIGITS     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 135_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           key_code,
    input  logic                 key_valid,
    output logic [OPERAND_W-1:0] operand_a,
    output logic [OPERAND_W-1:0] operand_b,
    output logic [1:0]           op,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [OPERAND_W-1:0] display_value,
    output logic [1:0]           entry_state
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

    logic       key_event;
    logic [3:0] event_code;

    entry_state_t          state_q, state_d;
    logic [OPERAND_W-1:0]  a_q, a_d, b_q, b_d;
    op_t                   op_q, op_d;
    logic [CNT_W-1:0]      a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic                  fresh_q, fresh_d;
    logic                  timeout_hit;

    key_event_detect u_key_event_detect (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_event  (key_event),
        .event_code (event_code)
    );

`ifdef OPERAND_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] idle_q, idle_d;
    logic             idle_active;

    // Idle counting only while a partial entry exists; a pending request never times out
    always_comb begin
        idle_active = ((state_q == StA) && (a_cnt_q != '0)) || (state_q == StOp) ||
                      (state_q == StB);
        timeout_hit = idle_active && !key_event &&
                      ((idle_q + 1'b1) == TMO_W'(TIMEOUT_CYCLES));
        idle_d      = (!idle_active || key_event || timeout_hit) ? '0 : idle_q + 1'b1;
    end

    // Idle counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    // Parameter kept for a uniform interface; only the timeout build uses it
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout_hit           = 1'b0;
`endif

    // Entry FSM next-state: clear first, then per-state key handling, then timeout
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        fresh_d = fresh_q;

        if ((key_event && event_code == KEY_CLR) || timeout_hit) begin
            state_d = StA;
            a_d     = '0;
            b_d     = '0;
            op_d    = OpAdd;
            a_cnt_d = '0;
            b_cnt_d = '0;
            fresh_d = 1'b0;
        end else begin
            unique case (state_q)
                StA: begin
                    if (key_event && is_digit(event_code)) begin
                        if (fresh_q) begin
                            // New calculation: drop the previous A
                            a_d     = acc_digit('0, event_code);
                            a_cnt_d = CNT_W'(1);
                            fresh_d = 1'b0;
                        end else if (a_cnt_q < CNT_W'(MAX_DIGITS)) begin
                            a_d     = acc_digit(a_q, event_code);
                            a_cnt_d = a_cnt_q + 1'b1;
                        end
                    end else if (key_event && is_operator(event_code) && a_cnt_q != '0) begin
                        // Also covers chaining the previous A after a completed request
                        op_d    = key_to_op(event_code);
                        state_d = StOp;
                        fresh_d = 1'b0;
                    end
                end
                StOp: begin
                    if (key_event && is_operator(event_code)) begin
                        op_d = key_to_op(event_code);
                    end else if (key_event && is_digit(event_code)) begin
                        b_d     = acc_digit('0, event_code);
                        b_cnt_d = CNT_W'(1);
                        state_d = StB;
                    end
                end
                StB: begin
                    if (key_event && is_digit(event_code)) begin
                        if (b_cnt_q < CNT_W'(MAX_DIGITS)) begin
                            b_d     = acc_digit(b_q, event_code);
                            b_cnt_d = b_cnt_q + 1'b1;
                        end
                    end else if (key_event && event_code == KEY_EQ) begin
                        state_d = StReq;
                    end
                end
                StReq: begin
                    if (req_ready) begin
                        state_d = StA;
                        fresh_d = 1'b1;
                    end
                end
                default: state_d = StA;
            endcase
        end
    end

    // Entry FSM state and operand registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StA;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OpAdd;
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
            fresh_q <= fresh_d;
        end
    end

    // Outputs are pure functions of registered state, so req_ready never reaches req_valid
    always_comb begin
        operand_a     = a_q;
        operand_b     = b_q;
        op            = op_q;
        req_valid     = (state_q == StReq);
        display_value = (state_q == StB || state_q == StReq) ? b_q : a_q;
        entry_state   = state_q;
    end

endmodule
